apb_slave_responder30: RTL and testbench
========================================

# apb_slave_responder30

APB completer (slave) that answers transfers driven by an APB master on the pclock30 domain. It decodes one psel30 bit and services reads and writes to a bank of 32-bit registers with a fixed, parameterised number of wait states. It optionally flags out-of-range or misaligned accesses on pslverr30. It sits at the slave end of the APB bus and is the DUT-side counterpart used to close the loop with the APB master interface in block- and SoC-level benches.

## Interface
- PADDR_WIDTH30, 32: address width.
- PWDATA_WIDTH30, 32: write data width; must equal PRDATA_WIDTH30.
- PRDATA_WIDTH30, 32: read data width.
- NUM_REGS30, 8: number of 32-bit registers; power of two, 2..64.
- BASE_ADDR30, 32'h0: byte address of register 0; aligned to 4*NUM_REGS30.
- WAIT_CYCLES30, 0: access-phase cycles with pready30 low before completion; range 0..15.
- pclock30  in  1  APB clock; all logic is posedge.
- preset30  in  1  asynchronous active-low reset.
- psel30  in  1  slave select; one bit of the master's 16-bit psel bus.
- penable30  in  1  access-phase strobe.
- prwd30  in  1  1 = write, 0 = read.
- paddr30  in  PADDR_WIDTH30  byte address.
- pwdata30  in  PWDATA_WIDTH30  write data.
- prdata30  out  PRDATA_WIDTH30  read data; registered.
- pready30  out  1  transfer completion.
- pslverr30  out  1  transfer error; valid only while pready30 = 1.
- reg_q30  out  32*NUM_REGS30  flattened register contents; register i is reg_q30[32*i +: 32].

## Operation
- FSM states:
  - IDLE:
    - psel30 & !penable30 (setup phase): latch paddr30, prwd30 and pwdata30; clear the wait counter; go to ACCESS.
    - penable30 without a preceding setup phase: ignored; stay in IDLE.
  - ACCESS:
    - !psel30 (master abort): go to IDLE; no write; no error.
    - Otherwise, if wait counter == WAIT_CYCLES30: complete the transfer and go to IDLE.
    - Otherwise: increment the wait counter.
- Address decode:
  - in-range = latched address in [BASE_ADDR30, BASE_ADDR30 + 4*NUM_REGS30 - 1] and address[1:0] == 0.
  - Index = address[2 +: log2(NUM_REGS30)].
- Write: the register is updated at the completion edge only (psel30 & penable30 & pready30 & prwd30 & in-range).
- Read: prdata30 is loaded at the setup edge with the indexed register, or 0 if out of range or a write. It holds that value until the next setup edge.
- Back-to-back transfers: after a completion the FSM is in IDLE, so a new setup phase in the very next cycle is accepted. This gives no idle-cycle penalty beyond the APB protocol itself.
- Data written in transfer N is returned by a read in transfer N+1.

## Timing
- Reset (preset30 low, asynchronous):
  - FSM goes to IDLE and the wait counter clears.
  - All registers, prdata30, pready30 and pslverr30 go to 0.
- Reset mid-transfer: the transfer is dropped; no write occurs.
- pready30 = (state == ACCESS) && (cnt == WAIT_CYCLES30). It is decoded from registered state only, with no combinational path from inputs.
- Transfer length:
  - Setup phase: 1 cycle.
  - Access phase: WAIT_CYCLES30 + 1 cycles.
  - Total: WAIT_CYCLES30 + 2 cycles, inclusive of setup.
- pready30 stays high for exactly one cycle per transfer.
- pslverr30 = pready30 & !in-range when the error feature is compiled in; otherwise 0.

## Configuration
- APB_RESP_SLVERR30_EN:
  - Defined:
    - An out-of-range or misaligned access completes with pslverr30 = 1.
    - A write to such an address is discarded.
    - A read returns 0.
  - Undefined:
    - pslverr30 is tied to 0.
    - Out-of-range and misaligned writes are silently discarded; reads return 0.
    - Timing is identical in both builds.

## Structure
- Package apb_resp_pkg30 holds:
  - the FSM state enum (IDLE, ACCESS);
  - the register-width constant (32);
  - a function computing the register index and in-range flag from an address, base and register count.
- One sub-module, apb_resp_regfile30:
  - the register array with synchronous write enable;
  - asynchronous clear on reset;
  - a read mux and the flattened reg_q30 output.
- The top level contains the FSM, the wait counter and the decode logic.

## Test plan
- Reset: hold preset30 low, then release → all outputs 0 and reg_q30 all 0; a stray penable30 = 1 with psel30 = 0 produces no pready30.
- WAIT_CYCLES30 = 0: write 32'hDEADBEEF to BASE+8, then read BASE+8 → pready30 high in the first access cycle; prdata30 = 32'hDEADBEEF; reg_q30[95:64] = 32'hDEADBEEF.
- WAIT_CYCLES30 = 3: read → pready30 low for 3 access cycles, high on the 4th; total transfer is 5 cycles.
- Error build: write 32'h1 to BASE+4*NUM_REGS30, then to BASE+2 → pslverr30 = 1 with pready30 on both; no register changes.
- Master abort: drop psel30 during a wait cycle of a write → no write; the FSM is back in IDLE and the next transfer completes normally.
- Back-to-back: 4 consecutive writes with no idle cycles, then preset30 asserted during the access phase of a 5th → first 4 registers updated, 5th dropped, everything cleared to 0.

Source files
------------

// File: rtl/apb_resp_pkg30.sv
// Shared types and helpers for the APB completer apb_slave_responder30.
//   state_e      : two-state transfer FSM (IDLE, ACCESS)
//   REG_W        : register width in bits (32)
//   dec_t        : result of an address decode (in-range flag + register index)
//   decode_addr  : maps a byte address onto the register bank
package apb_resp_pkg30;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam int REG_W     = 32;
  localparam int IDX_MAX_W = 6;   // enough for the largest bank (64 registers)

  typedef struct packed {
    logic                 in_range;
    logic [IDX_MAX_W-1:0] idx;
  } dec_t;

  // Address is in range when it falls inside the bank window and is word
  // aligned. The base is aligned to the bank size, so the index can be taken
  // straight from the low address bits and masked to the bank size.
  function automatic dec_t decode_addr(input logic [63:0] addr,
                                       input logic [63:0] base,
                                       input int unsigned num_regs);
    dec_t        d;
    logic [63:0] span;
    span       = 64'(num_regs) << 2;
    d.in_range = (addr >= base) && ((addr - base) < span) && (addr[1:0] == 2'b00);
    d.idx      = addr[7:2] & IDX_MAX_W'(num_regs - 1);
    return d;
  endfunction

endpackage

// File: rtl/apb_resp_regfile30.sv
// Register bank for apb_slave_responder30.
//   clk, rst_n : clock, asynchronous active-low clear of every register
//   we         : write enable, widx/wdata select and supply the written word
//   ridx/rdata : combinational read port
//   reg_q      : all registers flattened, register i at reg_q[32*i +: 32]
module apb_resp_regfile30
  import apb_resp_pkg30::*;
#(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [IDX_W-1:0]          widx,
  input  logic [REG_W-1:0]          wdata,
  input  logic [IDX_W-1:0]          ridx,
  output logic [REG_W-1:0]          rdata,
  output logic [REG_W*NUM_REGS-1:0] reg_q
);

  logic [NUM_REGS-1:0][REG_W-1:0] regs_q, regs_d;

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[widx] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  assign rdata = regs_q[ridx];
  assign reg_q = regs_q;

endmodule

// File: rtl/apb_slave_responder30.sv
// APB completer: services reads/writes to a bank of 32-bit registers with a
// fixed number of access-phase wait states.
//   pclock30, preset30       : clock, asynchronous active-low reset
//   psel30, penable30, prwd30, paddr30, pwdata30 : APB request from the master
//   prdata30                 : read data, loaded at the setup edge
//   pready30                 : one-cycle completion strobe
//   pslverr30                : error on out-of-range / misaligned access
//   reg_q30                  : flattened register contents
// Build option: define APB_RESP_SLVERR30_EN to drive pslverr30; without it
// pslverr30 is tied low. Bad-address writes are dropped in both builds.
module apb_slave_responder30
  import apb_resp_pkg30::*;
#(
  parameter int          PADDR_WIDTH30  = 32,
  parameter int          PWDATA_WIDTH30 = 32,
  parameter int          PRDATA_WIDTH30 = 32,
  parameter int          NUM_REGS30     = 8,
  parameter logic [31:0] BASE_ADDR30    = 32'h0,
  parameter int          WAIT_CYCLES30  = 0
) (
  input  logic                        pclock30,
  input  logic                        preset30,
  input  logic                        psel30,
  input  logic                        penable30,
  input  logic                        prwd30,
  input  logic [PADDR_WIDTH30-1:0]    paddr30,
  input  logic [PWDATA_WIDTH30-1:0]   pwdata30,
  output logic [PRDATA_WIDTH30-1:0]   prdata30,
  output logic                        pready30,
  output logic                        pslverr30,
  output logic [32*NUM_REGS30-1:0]    reg_q30
);

  localparam int IDX_W = $clog2(NUM_REGS30);

  state_e                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic                      wr_q, wr_d;
  logic                      in_range_q, in_range_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [REG_W-1:0]          wdata_q, wdata_d;
  logic [PRDATA_WIDTH30-1:0] prdata_q, prdata_d;

  dec_t             dec_in;
  logic [IDX_W-1:0] ridx;
  logic [REG_W-1:0] rd_data;
  logic             setup;
  logic             we;

  // Decode the live address; the result is captured at the setup edge so
  // the access phase works only from registered values.
  assign dec_in = decode_addr(64'(paddr30), 64'(BASE_ADDR30), NUM_REGS30);
  assign ridx   = dec_in.idx[IDX_W-1:0];
  assign setup  = (state_q == IDLE) && psel30 && !penable30;

  assign pready30 = (state_q == ACCESS) && (cnt_q == 4'(WAIT_CYCLES30));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    in_range_d = in_range_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    prdata_d   = prdata_q;
    unique case (state_q)
      IDLE: begin
        // A lone penable30 without a setup phase is ignored.
        if (setup) begin
          wr_d       = prwd30;
          in_range_d = dec_in.in_range;
          idx_d      = ridx;
          wdata_d    = REG_W'(pwdata30);
          cnt_d      = '0;
          prdata_d   = (!prwd30 && dec_in.in_range) ? PRDATA_WIDTH30'(rd_data) : '0;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (!psel30)       state_d = IDLE;   // master abort
        else if (pready30) state_d = IDLE;   // completion
        else               cnt_d   = cnt_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Commit only at the completion edge of a live, in-range write.
  assign we = psel30 && penable30 && pready30 && wr_q && in_range_q;

  always_ff @(posedge pclock30 or negedge preset30) begin
    if (!preset30) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      in_range_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      prdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      in_range_q <= in_range_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      prdata_q   <= prdata_d;
    end
  end

  assign prdata30 = prdata_q;

`ifdef APB_RESP_SLVERR30_EN
  assign pslverr30 = pready30 & ~in_range_q;
`else
  assign pslverr30 = 1'b0;
`endif

  apb_resp_regfile30 #(
    .NUM_REGS (NUM_REGS30),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk   (pclock30),
    .rst_n (preset30),
    .we    (we),
    .widx  (idx_q),
    .wdata (wdata_q),
    .ridx  (ridx),
    .rdata (rd_data),
    .reg_q (reg_q30)
  );

endmodule

// File: tb/tb_apb_slave_responder30.sv
// Bench for apb_slave_responder30: two instances (0 and 3 wait states) with
// separate buses, a shared clock/reset, a register model and an expected-
// response queue popped on pready30.
module tb_apb_slave_responder30;

  localparam int          NR = 8;
  localparam logic [31:0] B0 = 32'h0;
  localparam logic [31:0] B1 = 32'h100;
`ifdef APB_RESP_SLVERR30_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          psel[2], penable[2], prwd[2];
  logic [31:0]   paddr[2], pwdata[2], prdata[2];
  logic          pready[2], pslverr[2];
  logic [32*NR-1:0] regq[2];

  logic [31:0] mdl[2][NR];
  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;

  apb_slave_responder30 #(.NUM_REGS30(NR), .BASE_ADDR30(B0), .WAIT_CYCLES30(0)) u_dut0 (
    .pclock30(clk), .preset30(rst_n), .psel30(psel[0]), .penable30(penable[0]),
    .prwd30(prwd[0]), .paddr30(paddr[0]), .pwdata30(pwdata[0]), .prdata30(prdata[0]),
    .pready30(pready[0]), .pslverr30(pslverr[0]), .reg_q30(regq[0]));

  apb_slave_responder30 #(.NUM_REGS30(NR), .BASE_ADDR30(B1), .WAIT_CYCLES30(3)) u_dut3 (
    .pclock30(clk), .preset30(rst_n), .psel30(psel[1]), .penable30(penable[1]),
    .prwd30(prwd[1]), .paddr30(paddr[1]), .pwdata30(pwdata[1]), .prdata30(prdata[1]),
    .pready30(pready[1]), .pslverr30(pslverr[1]), .reg_q30(regq[1]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_regs(input int d, input string tag);
    for (int i = 0; i < NR; i++) chk(tag, regq[d][32*i +: 32], mdl[d][i]);
  endtask

  task automatic clr_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NR; i++) mdl[d][i] = '0;
  endtask

  task automatic chk_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_prdata"}, prdata[d], 0);
      chk({tag, "_pready"}, pready[d], 0);
      chk({tag, "_pslverr"}, pslverr[d], 0);
      chk({tag, "_regq"}, (regq[d] == '0), 1);
    end
  endtask

  task automatic idle(input int d);
    psel[d] = 1'b0; penable[d] = 1'b0;
    @(negedge clk);
    chk("pready_idle", pready[d], 0);
    @(posedge clk); #1;
  endtask

  // One complete transfer; returns #1 after the completion edge with the
  // bus still driven so the caller may start a back-to-back setup.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t        e;
    logic [31:0] base;
    bit          inr, ok;
    int          idx, n;
    base = (d == 0) ? B0 : B1;
    inr  = (addr >= base) && ((addr - base) < 4*NR) && (addr[1:0] == 2'b00);
    idx  = inr ? int'((addr - base) >> 2) : 0;
    e.rdata = (!wr && inr) ? mdl[d][idx] : 32'h0;
    e.err   = ERR_EN && !inr;
    sbq.push_back(e);
    psel[d] = 1'b1; penable[d] = 1'b0; prwd[d] = wr; paddr[d] = addr; pwdata[d] = wdata;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    n = 0; ok = 1'b0;
    while (!ok && n < 40) begin
      @(negedge clk);
      n++;
      if (pready[d]) ok = 1'b1;
      else chk("pslverr_wait", pslverr[d], 0);
    end
    chk("timeout", ok, 1);
    e = sbq.pop_front();
    if (ok) begin
      chk("prdata", prdata[d], e.rdata);
      chk("pslverr", pslverr[d], e.err);
      chk("access_cycles", n, (d == 0) ? 1 : 4);
    end
    @(posedge clk); #1;
    if (wr && inr) mdl[d][idx] = wdata;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      psel[d] = 0; penable[d] = 0; prwd[d] = 0; paddr[d] = 0; pwdata[d] = 0;
    end
    clr_model();

    // Reset
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_zero("reset");
    // Stray penable without psel / setup
    penable[0] = 1'b1; penable[1] = 1'b1;
    @(negedge clk);
    chk("stray_pready0", pready[0], 0);
    chk("stray_pready1", pready[1], 0);
    @(posedge clk); #1;
    penable[0] = 1'b0; penable[1] = 1'b0;

    // Zero wait states: write, idle, read, then write/read back-to-back
    xfer(0, 1, B0 + 8, 32'hDEADBEEF);
    idle(0);
    xfer(0, 0, B0 + 8, 0);
    chk("regq_95_64", regq[0][95:64], 32'hDEADBEEF);
    xfer(0, 1, B0 + 28, 32'h1234_5678);
    xfer(0, 0, B0 + 28, 0);
    idle(0);
    chk_regs(0, "regs0_a");

    // Three wait states
    xfer(1, 1, B1 + 8, 32'hCAFE_0001);
    xfer(1, 0, B1 + 8, 0);
    xfer(1, 0, B1 + 4, 0);
    idle(1);

    // Bad addresses: out of range and misaligned
    xfer(0, 1, B0 + 4*NR, 32'h1);
    xfer(0, 1, B0 + 2, 32'h1);
    xfer(0, 0, B0 + 4*NR, 0);
    xfer(0, 0, B0 + 10, 0);
    idle(0);
    chk_regs(0, "regs0_err");

    // Master abort during a wait cycle of a write
    xfer(1, 1, B1 + 20, 32'h5);
    idle(1);
    psel[1] = 1; penable[1] = 0; prwd[1] = 1; paddr[1] = B1 + 20; pwdata[1] = 32'hAAAA;
    @(posedge clk); #1 penable[1] = 1;
    @(negedge clk);
    chk("abort_pready", pready[1], 0);
    @(posedge clk); #1;
    idle(1);
    chk_regs(1, "regs1_abort");
    xfer(1, 0, B1 + 20, 0);
    idle(1);

    // Back-to-back writes, then reset during the access phase of a fifth
    for (int i = 0; i < 4; i++) xfer(1, 1, B1 + 4*i, 32'h1000 + i);
    chk_regs(1, "regs1_b2b");
    psel[1] = 1; penable[1] = 0; prwd[1] = 1; paddr[1] = B1 + 16; pwdata[1] = 32'hBAD;
    @(posedge clk); #1 penable[1] = 1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    clr_model();
    chk_zero("midreset");
    psel[1] = 0; penable[1] = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("post_reset");
    chk_regs(1, "regs1_post");

    // Normal operation resumes
    xfer(1, 1, B1 + 12, 32'h77);
    xfer(1, 0, B1 + 12, 0);
    idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
